// File: rtl/seq_stream_ctrl.sv
// Word-to-bit serialiser feeding a programmable overlapping pattern matcher.
// Optional saturating match counter enabled by defining MATCH_COUNT_EN.
module seq_stream_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 8,
  parameter int LEN_W  = 4
`ifdef MATCH_COUNT_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              cfg_load,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              match,
  output logic              cfg_err
`ifdef MATCH_COUNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  match_cnt
`endif
);

  localparam int               IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  seen_q, seen_d;
  logic              shifted_q, shifted_d;
  logic              match_q, match_d;
  logic              cfg_err_q, cfg_err_d;
  logic [PAT_W-1:0]  len_mask;
  logic              last_bit;
  logic              accept;
  logic              cfg_take;

  assign last_bit = (idx_q == IDX_LAST);
  assign accept   = s_valid & s_ready;
  assign cfg_take = cfg_load & (state_q == IDLE);
  assign len_mask = ~({PAT_W{1'b1}} << len_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      hist_q    <= '0;
      pat_q     <= '0;
      len_q     <= LEN_MAX;
      seen_q    <= '0;
      shifted_q <= 1'b0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      hist_q    <= hist_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      seen_q    <= seen_d;
      shifted_q <= shifted_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_bit && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    hist_d    = hist_q;
    pat_d     = pat_q;
    len_d     = len_q;
    seen_d    = seen_q;
    shifted_d = 1'b0;
    cfg_err_d = cfg_load & (state_q == SHIFT);
    // Compare the history left by the previous edge's shift; this is what registers match.
    match_d   = shifted_q && (seen_q >= len_q) &&
                ((hist_q & len_mask) == (pat_q & len_mask));
    if (state_q == SHIFT) begin
      hist_d    = {hist_q[PAT_W-2:0], shreg_q[WORD_W-1]};
      shreg_d   = shreg_q << 1;
      idx_d     = idx_q + IDX_W'(1);
      shifted_d = 1'b1;
      if (seen_q != LEN_MAX) seen_d = seen_q + LEN_W'(1);
    end else if (cfg_take) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      hist_d = '0;
      seen_d = '0;
    end
    if (accept) begin
      shreg_d = s_data;
      idx_d   = '0;
    end
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE:    s_ready = enable & ~cfg_load;
      SHIFT: begin
        busy    = 1'b1;
        s_ready = last_bit & enable & ~cfg_load;
      end
      default: ;
    endcase
    s_ready = s_ready & reset_n;
  end

  assign match   = match_q;
  assign cfg_err = cfg_err_q;

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear wins over a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr || cfg_take) cnt_d = '0;
    else if (match_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Bench for seq_stream_ctrl: directed scenarios plus random traffic against a
// queue-based model of the bit stream, history and pattern rules.
module tb_seq_stream_ctrl;
  localparam int WORD_W = 8;
  localparam int PAT_W  = 8;
  localparam int LEN_W  = 4;
`ifdef MATCH_COUNT_EN
  localparam int CNT_W  = 2;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              cfg_load;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [LEN_W-1:0]  cfg_len;
  logic              s_valid;
  logic [WORD_W-1:0] s_data;
  logic              s_ready;
  logic              busy;
  logic              match;
  logic              cfg_err;
`ifdef MATCH_COUNT_EN
  logic              cnt_clr;
  logic [CNT_W-1:0]  match_cnt;
`endif

  seq_stream_ctrl #(
    .WORD_W(WORD_W), .PAT_W(PAT_W), .LEN_W(LEN_W)
`ifdef MATCH_COUNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .busy(busy), .match(match),
    .cfg_err(cfg_err)
`ifdef MATCH_COUNT_EN
    , .cnt_clr(cnt_clr), .match_cnt(match_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bits still to send, recent bit history, active pattern.
  bit               m_bits[$];
  bit               m_hist[$];
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_pend, m_match, m_err;
  int               m_cnt;
  logic             pre_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic int eff_len(input logic [LEN_W-1:0] l);
    return (l == 0 || int'(l) > PAT_W) ? PAT_W : int'(l);
  endfunction

  function automatic bit hit();
    int n = m_hist.size();
    if (n < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (m_hist[n-1-i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_hist.delete();
    m_pat   = '0;
    m_len   = PAT_W;
    m_pend  = 1'b0;
    m_match = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_edge();
    bit was_busy, rdy, cfg_ok, clr;
    was_busy = (m_bits.size() > 0);
    rdy      = enable && !cfg_load && (m_bits.size() <= 1);
    m_match  = m_pend;
    m_pend   = 1'b0;
    if (was_busy) begin
      m_hist.push_back(m_bits.pop_front());
      if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
      m_pend = hit();
    end
    m_err  = cfg_load && was_busy;
    cfg_ok = cfg_load && !was_busy;
    if (cfg_ok) begin
      m_pat = cfg_pattern;
      m_len = eff_len(cfg_len);
      m_hist.delete();
    end
    if (s_valid && rdy)
      for (int i = WORD_W - 1; i >= 0; i--) m_bits.push_back(s_data[i]);
    clr = cfg_ok;
`ifdef MATCH_COUNT_EN
    clr = clr || cnt_clr;
    if (clr) m_cnt = 0;
    else if (m_match && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`else
    if (clr) m_cnt = 0;
`endif
  endtask

  // One clock: check combinational outputs before the edge, registered ones after.
  task automatic step();
    logic exp_rdy;
    #1;
    exp_rdy = enable && !cfg_load && (m_bits.size() <= 1);
    pre_rdy = s_ready;
    check("s_ready", s_ready, exp_rdy);
    check("busy_pre", busy, m_bits.size() > 0);
    @(posedge clk);
    model_edge();
    #1;
    check("match", match, m_match);
    check("cfg_err", cfg_err, m_err);
    check("busy", busy, m_bits.size() > 0);
`ifdef MATCH_COUNT_EN
    check("match_cnt", match_cnt, m_cnt);
`endif
    @(negedge clk);
  endtask

  task automatic load_cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    step();
    cfg_load    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] mvec, bvec, rvec, evec;
    reset_n = 1'b0; enable = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    s_valid = 1'b0; s_data = '0;
`ifdef MATCH_COUNT_EN
    cnt_clr = 1'b0;
`endif
    model_reset();
    #3;
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_match", match, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Pattern 101 over 8'hA8: hits after edges t+4 and t+6, busy after t..t+7.
    load_cfg(8'b101, 4'd3);
    mvec = '0; bvec = '0;
    s_valid = 1'b1; s_data = 8'hA8;
    for (int k = 0; k < 10; k++) begin
      step();
      s_valid = 1'b0;
      mvec[k] = match; bvec[k] = busy;
    end
    check("t1_match", 32'(mvec[9:0]), 32'b00_0101_0000);
    check("t1_busy", 32'(bvec[9:0]), 32'b00_1111_1111);

    // Back-to-back 8'hFF, 8'h00 with pattern 10: no bubble, one hit at t+10.
    load_cfg(8'b10, 4'd2);
    mvec = '0; rvec = '0;
    s_valid = 1'b1; s_data = 8'hFF;
    for (int k = 0; k < 12; k++) begin
      step();
      s_data = 8'h00;
      if (k == 8) s_valid = 1'b0;
      mvec[k] = match; rvec[k] = pre_rdy;
    end
    check("t2_ready", 32'(rvec), 32'b0001_0000_0001);
    check("t2_match", 32'(mvec), 32'b0100_0000_0000);
    repeat (6) step();

    // cfg_load while shifting is rejected; pattern 1 keeps matching the ones of 8'hF0.
    load_cfg(8'h01, 4'd1);
    mvec = '0; evec = '0;
    s_valid = 1'b1; s_data = 8'hF0;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) begin cfg_load = 1'b1; cfg_pattern = 8'h00; end
      step();
      s_valid = 1'b0; cfg_load = 1'b0;
      mvec[k] = match; evec[k] = cfg_err;
    end
    check("t3_cfg_err", 32'(evec), 32'b0000_0000_0100);
    check("t3_match_old_pat", 32'(mvec), 32'b0000_0011_1100);
    // cfg_load with s_valid in IDLE: configuration wins, word not taken.
    cfg_load = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd1; s_valid = 1'b1; s_data = 8'hFF;
    step();
    check("t3_ready_blocked", pre_rdy, 1'b0);
    check("t3_not_busy", busy, 1'b0);
    cfg_load = 1'b0; s_data = 8'h0F;
    mvec = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      s_valid = 1'b0;
      mvec[k] = match;
    end
    check("t3_match_new_pat", 32'(mvec), 32'b0000_0011_1100);

    // enable dropped mid-word: word completes, nothing else accepted, pending hit emitted.
    mvec = '0; bvec = '0; rvec = '0;
    s_valid = 1'b1; s_data = 8'hAA;
    for (int k = 0; k < 11; k++) begin
      if (k == 3) enable = 1'b0;
      step();
      mvec[k] = match; bvec[k] = busy; rvec[k] = pre_rdy;
    end
    check("t4_ready", 32'(rvec[10:0]), 32'b000_0000_0001);
    check("t4_busy", 32'(bvec[10:0]), 32'b000_1111_1111);
    check("t4_match", 32'(mvec[10:0]), 32'b010_1010_1000);
    enable = 1'b1; s_valid = 1'b0;

    // Asynchronous reset mid-word discards the word and any pending hit.
    load_cfg(8'h01, 4'd1);
    s_valid = 1'b1; s_data = 8'hFF;
    step();
    s_valid = 1'b0;
    repeat (4) step();
    check("t5_match_before", match, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_match", match, 1'b0);
    check("t5_rst_ready", s_ready, 1'b0);
    check("t5_rst_cfg_err", cfg_err, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();
    // Reset pattern is eight zeros: only a full fresh word of zeros may hit.
    mvec = '0;
    s_valid = 1'b1; s_data = 8'h00;
    for (int k = 0; k < 11; k++) begin
      step();
      s_valid = 1'b0;
      mvec[k] = match;
    end
    check("t5_match_after", 32'(mvec[10:0]), 32'b010_0000_0000);

`ifdef MATCH_COUNT_EN
    load_cfg(8'h01, 4'd1);
    s_valid = 1'b1; s_data = 8'hFF;
    step();
    s_valid = 1'b0;
    repeat (10) step();
    check("t6_cnt_sat", 32'(match_cnt), 32'd3);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("t6_cnt_clr", 32'(match_cnt), 32'd0);
`endif

    // Random traffic; short patterns keep hits frequent.
    for (int n = 0; n < 600; n++) begin
      enable   = ($urandom_range(0, 7) != 0);
      s_valid  = 1'($urandom_range(0, 1));
      s_data   = WORD_W'($urandom);
      cfg_load = ($urandom_range(0, 15) == 0);
      cfg_pattern = PAT_W'($urandom);
      cfg_len  = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15))
                                             : LEN_W'($urandom_range(1, 3));
`ifdef MATCH_COUNT_EN
      cnt_clr  = ($urandom_range(0, 31) == 0);
`endif
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
